// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file write path.
//   NUM_REGS / ADDR_W / DATA_W : architectural register file geometry
//   ZERO_REG                   : hard-wired zero register (writes discarded)
//   wr_req_t                   : one pending write {addr, data}
//   onehot_dec()               : address -> one-hot register select
package regfile_pkg;

  localparam int NUM_REGS = 32;
  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 64;
  localparam logic [ADDR_W-1:0] ZERO_REG = ADDR_W'(31);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_req_t;

  function automatic logic [NUM_REGS-1:0] onehot_dec(input logic [ADDR_W-1:0] addr);
    logic [NUM_REGS-1:0] v;
    v       = '0;
    v[addr] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/regfile_wr_decoder.sv
// Combinational ADDR_W -> NUM_REGS one-hot decoder with enable.
// Shared between the write-enable path and the read-side mux select.
//   en     : 0 forces an all-zero output
//   addr   : register index
//   onehot : one-hot select, at most one bit set
module regfile_wr_decoder
  import regfile_pkg::*;
(
  input  logic                en,
  input  logic [ADDR_W-1:0]   addr,
  output logic [NUM_REGS-1:0] onehot
);

  assign onehot = en ? onehot_dec(addr) : '0;

endmodule

// File: rtl/regfile_write_port.sv
// Write-side front end of the register file.
// Buffers write-back requests in a small FIFO and drains at most one per
// cycle into a registered one-hot write-enable / data stage that feeds the
// storage cell array. A combinational bypass exposes writes that are queued
// or in the output stage but not yet captured by the array.
//   clk, reset               : clock; asynchronous active-low reset
//   req_valid/ready/addr/data: write request handshake
//   array_hold               : 1 = do not drain this cycle
//   wr_en, wr_data           : registered write strobe/data to the array
//   byp_addr/hit/data        : pending-write lookup for readers
//   pending                  : any write still in flight
module regfile_write_port
  import regfile_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_data,
  input  logic                array_hold,
  output logic [NUM_REGS-1:0] wr_en,
  output logic [DATA_W-1:0]   wr_data,
  input  logic [ADDR_W-1:0]   byp_addr,
  output logic                byp_hit,
  output logic [DATA_W-1:0]   byp_data,
  output logic                pending
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  // Pointers wrap mod DEPTH explicitly so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  wr_req_t               mem_q [DEPTH];
  wr_req_t               mem_d [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  ready_en_q, ready_en_d;
  logic [NUM_REGS-1:0]   wr_en_q, wr_en_d;
  logic [DATA_W-1:0]     wr_data_q, wr_data_d;
  logic                  out_valid_q, out_valid_d;
  logic [ADDR_W-1:0]     out_addr_q, out_addr_d;

  logic                  push, pop;
  wr_req_t               head;
  logic [NUM_REGS-1:0]   dec_onehot;
  logic [PTR_W-1:0]      byp_idx;

  // ready_en_q keeps req_ready low while reset is held and for the cycle of
  // release; ready never looks at same-cycle drain, so a full FIFO never
  // passes a request straight through.
  assign req_ready = ready_en_q & (count_q < FULL_CNT);
  assign head      = mem_q[rd_ptr_q];
  // Zero-register requests complete the handshake but are never enqueued.
  assign push      = req_valid & req_ready & (req_addr != ZERO_REG);
  assign pop       = (count_q != '0) & ~array_hold;

  regfile_wr_decoder u_dec (
    .en     (pop & (head.addr != ZERO_REG)),
    .addr   (head.addr),
    .onehot (dec_onehot)
  );

  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    ready_en_d = 1'b1;

    if (push) begin
      mem_d[wr_ptr_q] = '{addr: req_addr, data: req_data};
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);

    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // Output stage: strobe for one cycle per drain; data holds otherwise.
    wr_en_d     = dec_onehot;
    out_valid_d = pop;
    wr_data_d   = pop ? head.data : wr_data_q;
    out_addr_d  = pop ? head.addr : out_addr_q;
  end

  // Bypass: oldest candidate first, later matches overwrite, so the newest
  // write (FIFO tail) wins over older entries and the output stage.
  always_comb begin
    byp_hit  = 1'b0;
    byp_data = '0;
    byp_idx  = rd_ptr_q;
    if (out_valid_q && out_addr_q == byp_addr) begin
      byp_hit  = 1'b1;
      byp_data = wr_data_q;
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (CNT_W'(i) < count_q && mem_q[byp_idx].addr == byp_addr) begin
        byp_hit  = 1'b1;
        byp_data = mem_q[byp_idx].data;
      end
      byp_idx = ptr_inc(byp_idx);
    end
    if (byp_addr == ZERO_REG) begin
      byp_hit  = 1'b0;
      byp_data = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_q       <= '{default: '0};
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      ready_en_q  <= 1'b0;
      wr_en_q     <= '0;
      wr_data_q   <= '0;
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
    end else begin
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      ready_en_q  <= ready_en_d;
      wr_en_q     <= wr_en_d;
      wr_data_q   <= wr_data_d;
      out_valid_q <= out_valid_d;
      out_addr_q  <= out_addr_d;
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_data = wr_data_q;
  assign pending = (count_q != '0) | out_valid_q;

endmodule
